// File: rtl/regfile_mp_swc.sv
// Multi-port register file with two write ports, NUM_RD registered read ports,
// write-to-read forwarding and a busy scoreboard for pending-write reservations.
module regfile_mp_swc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic                       hclk,
    input  logic                       hrstn,
    input  logic                       wen_a,
    input  logic [ADDR_W-1:0]          waddr_a,
    input  logic [DATA_W-1:0]          wdata_a,
    input  logic                       wen_b,
    input  logic [ADDR_W-1:0]          waddr_b,
    input  logic [DATA_W-1:0]          wdata_b,
    input  logic [NUM_RD-1:0]          ren,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(2**ADDR_W)-1:0]     busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_nxt_c;
    logic [ADDR_W-1:0] rd_addr_c [NUM_RD];
    logic [DATA_W-1:0] rd_data_c [NUM_RD];
    logic [NUM_RD-1:0] rd_busy_c;

    // Scoreboard next state: writes clear, a reserve on the same edge wins.
    always_comb begin
        busy_nxt_c = busy;
        if (wen_a) busy_nxt_c[waddr_a] = 1'b0;
        if (wen_b) busy_nxt_c[waddr_b] = 1'b0;
        if (rsv_en) busy_nxt_c[rsv_addr] = 1'b1;
        if (ZERO_R0 != 0) busy_nxt_c[0] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_addr_c[i] = raddr[i*ADDR_W +: ADDR_W];
        end
    end

    // Read mux with same-edge forwarding; port B is checked last so it wins.
    always_comb begin
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_data_c[i] = mem[rd_addr_c[i]];
            if (wen_a && (waddr_a == rd_addr_c[i])) rd_data_c[i] = wdata_a;
            if (wen_b && (waddr_b == rd_addr_c[i])) rd_data_c[i] = wdata_b;
            rd_busy_c[i] = busy_nxt_c[rd_addr_c[i]];
            if ((ZERO_R0 != 0) && (rd_addr_c[i] == '0)) begin
                rd_data_c[i] = '0;
                rd_busy_c[i] = 1'b0;
            end
        end
    end

    // Storage array; entry 0 is pinned to zero when ZERO_R0 is set.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            for (int n = 0; n < int'(DEPTH); n++) begin
                mem[n] <= '0;
            end
        end else begin
            for (int n = 0; n < int'(DEPTH); n++) begin
                if ((ZERO_R0 != 0) && (n == 0)) begin
                    mem[n] <= '0;
                end else if (wen_b && (waddr_b == ADDR_W'(n))) begin
                    mem[n] <= wdata_b;
                end else if (wen_a && (waddr_a == ADDR_W'(n))) begin
                    mem[n] <= wdata_a;
                end
            end
        end
    end

    // Registered read ports and scoreboard.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            rdata   <= '0;
            rd_busy <= '0;
            busy    <= '0;
        end else begin
            busy <= busy_nxt_c;
            for (int i = 0; i < int'(NUM_RD); i++) begin
                if (ren[i]) begin
                    rdata[i*DATA_W +: DATA_W] <= rd_data_c[i];
                    rd_busy[i]                <= rd_busy_c[i];
                end
            end
        end
    end

endmodule

// File: doc/regfile_mp_swc.md
REGFILE_MP_SWC -- requirements
Module: regfile_mp_swc

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth is 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of read ports, range 1..4.
REQ-004 Parameter ZERO_R0, default 1; when 1, entry 0 always reads 0 and ignores writes.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; the clock port SHALL be named hclk and the reset port hrstn.
REQ-006 hclk  in  1  clock; all state updates on its rising edge.
REQ-007 hrstn  in  1  asynchronous active-low reset.
REQ-008 wen_a  in  1  write enable, port A.
REQ-009 waddr_a  in  ADDR_W  write address, port A.
REQ-010 wdata_a  in  DATA_W  write data, port A.
REQ-011 wen_b, waddr_b, wdata_b  in  1/ADDR_W/DATA_W  write port B, same meaning as port A.
REQ-012 ren  in  NUM_RD  per-port read enable; bit i belongs to port i.
REQ-013 raddr  in  NUM_RD*ADDR_W  flattened read addresses; port i at [i*ADDR_W +: ADDR_W].
REQ-014 rdata  out  NUM_RD*DATA_W  flattened registered read data; port i at [i*DATA_W +: DATA_W].
REQ-015 rd_busy  out  NUM_RD  registered busy flag of the entry read on port i.
REQ-016 rsv_en  in  1  reserve request; marks an entry as awaiting a pending write.
REQ-017 rsv_addr  in  ADDR_W  address to reserve.
REQ-018 busy  out  2**ADDR_W  live scoreboard vector; bit n set means entry n is reserved.

Function
REQ-019 A write on port A or port B SHALL update the addressed entry on the rising edge where its enable is 1.
REQ-020 When wen_a and wen_b are both 1 with equal addresses, port B data SHALL be stored.
REQ-021 When ZERO_R0=1, writes to address 0 SHALL be discarded, a reserve of address 0 SHALL be ignored, and busy[0] SHALL stay 0.
REQ-022 A read SHALL have 1-cycle latency: on an edge with ren[i]=1, rdata port i loads the value of entry raddr[i].
REQ-023 On an edge with ren[i]=0, rdata port i and rd_busy[i] SHALL hold their previous values.
REQ-024 A same-cycle write to the read address SHALL be forwarded; the read returns the newly written data, with port B winning per REQ-020.
REQ-025 A write from either port SHALL clear busy[waddr] on the same edge.
REQ-026 rsv_en=1 SHALL set busy[rsv_addr] on the edge.
REQ-027 If a reserve and a write hit the same address on one edge, the reserve SHALL win and busy stays 1.
REQ-028 rd_busy[i] SHALL capture the post-edge busy value of raddr[i], with REQ-025 to REQ-027 applied on that edge.
REQ-029 When ZERO_R0=1, a read of address 0 SHALL return 0 and rd_busy 0, regardless of any same-cycle write.
REQ-030 All read ports SHALL be independent; any ports may read the same address in one cycle.
REQ-031 No combinational path SHALL exist from any input to rdata or rd_busy.
REQ-032 busy SHALL be a direct register output.

Reset
REQ-033 While hrstn=0, all entries, rdata, rd_busy and busy SHALL be 0, asynchronously.
REQ-034 Writes, reads or reserves in flight when reset asserts SHALL be lost.
REQ-035 The first edge after hrstn rises SHALL operate normally.

Verification
REQ-036 Reset, then write 0xDEADBEEF to address 5 on port A, read port 0 at address 5 next cycle -> rdata port 0 = 0xDEADBEEF one cycle later.
REQ-037 Same-edge writes: port A writes 0x11111111 and port B writes 0x22222222, both to address 7; ports 0 and 1 read address 7 on that edge -> both return 0x22222222, and the later stored value is 0x22222222.
REQ-038 ZERO_R0=1: write 0xFFFFFFFF to address 0 and reserve address 0 -> read of address 0 returns 0, busy[0]=0.
REQ-039 Reserve address 3 -> busy[3]=1 next cycle; write address 3 while reserving address 3 -> busy[3] stays 1; a later write alone -> busy[3]=0, and a same-edge read gives rd_busy=0.
REQ-040 Hold ren[1]=0 for 3 cycles while address 9 is rewritten -> rdata port 1 unchanged; then assert hrstn=0 mid-cycle -> all outputs 0 without waiting for a clock edge.
